// File: rtl/viterbi_pkg.sv
// Shared definitions for the convolutional encoder and the Viterbi decoder (ACS/TBU).
// Holds code constraint length, trellis state type, default generator polynomials,
// encoder FSM states, puncture masks and the symbol computation helper.
package viterbi_pkg;

    localparam int K          = 4;
    localparam int NUM_STATES = 1 << (K - 1);

    typedef logic [K-2:0] state_t;

    // Taps over the window w = {s[2], s[1], s[0], b}
    localparam logic [K-1:0] G0_DEFAULT = 4'b1011;
    localparam logic [K-1:0] G1_DEFAULT = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        TAIL
    } enc_fsm_t;

    // Tail length is K-1 symbols; the counter runs from K-2 down to 0
    localparam logic [1:0] TAIL_CNT_INIT = 2'(K - 2);

    localparam logic [1:0] MASK_FULL      = 2'b11;
    localparam logic [1:0] PUNC_MASK_EVEN = 2'b11;
    localparam logic [1:0] PUNC_MASK_ODD  = 2'b01;

    // Returns {sym1, sym0} for trellis state s and input bit b
    function automatic logic [1:0] conv_sym(input state_t s, input logic b,
                                            input logic [K-1:0] g0, input logic [K-1:0] g1);
        logic [K-1:0] w;
        w = {s, b};
        return {^(w & g1), ^(w & g0)};
    endfunction

endpackage

// File: rtl/conv_enc_trellis.sv
// Trellis state holder for the convolutional encoder.
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset
//   i_step   advance the state with i_bit this cycle
//   i_bit    current input bit b
//   i_clear  force state to 0 (end of tail flush); wins over i_step
//   o_sym    {sym1, sym0} for the current state and i_bit (combinational)
module conv_enc_trellis
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEFAULT,
    parameter logic [K-1:0] G1 = G1_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_step,
    input  logic       i_bit,
    input  logic       i_clear,
    output logic [1:0] o_sym
);

    state_t r_s;

    assign o_sym = conv_sym(r_s, i_bit, G0, G1);

    // Newest bit enters at the LSB, matching decoder state numbering
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s <= '0;
        end else if (i_clear) begin
            r_s <= '0;
        end else if (i_step) begin
            r_s <= {r_s[K-3:0], i_bit};
        end
    end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2, K=4 convolutional encoder with valid/ready byte input and symbol output.
// Bytes are serialised MSB first; after a byte flagged s_last, K-1 zero tail bits
// return the trellis to state 0. Optional rate-2/3 puncturing is enabled by
// defining CONV_ENC_PUNCTURE_EN (otherwise m_mask is constant 2'b11).
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   s_valid/s_ready   input byte handshake; s_data byte, s_last ends the frame
//   m_valid/m_ready   output symbol handshake
//   m_sym             {sym1, sym0}
//   m_mask            per-bit transmit mask (0 = punctured)
//   m_last            final tail symbol of the frame
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEFAULT,
    parameter logic [K-1:0] G1 = G1_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [1:0] m_sym,
    output logic [1:0] m_mask,
    output logic       m_last
);

    enc_fsm_t   r_state;
    enc_fsm_t   w_state_next;
    logic [7:0] r_byte;
    logic       r_last;
    logic [2:0] r_idx;
    logic [1:0] r_tail_cnt;
    logic       r_m_valid;
    logic [1:0] r_m_sym;
    logic       r_m_last;

    logic       w_adv;
    logic       w_accept;
    logic       w_frame_start;
    logic       w_step;
    logic       w_bit;
    logic       w_clear;
    logic [1:0] w_sym;

    assign w_adv         = !r_m_valid || m_ready;
    assign w_accept      = s_valid && s_ready;
    assign w_frame_start = w_accept && (r_state == IDLE);

    conv_enc_trellis #(
        .G0 (G0),
        .G1 (G1)
    ) u_trellis (
        .clk     (clk),
        .rst     (rst),
        .i_step  (w_step),
        .i_bit   (w_bit),
        .i_clear (w_clear),
        .o_sym   (w_sym)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = SHIFT;
            end
            SHIFT: begin
                if (w_adv && (r_idx == 3'd0)) begin
                    if (r_last)       w_state_next = TAIL;
                    else if (s_valid) w_state_next = SHIFT;
                    else              w_state_next = IDLE;
                end
            end
            TAIL: begin
                if (w_adv && (r_tail_cnt == 2'd0)) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs; s_ready never depends on s_valid
    always_comb begin
        s_ready = 1'b0;
        w_step  = 1'b0;
        w_bit   = 1'b0;
        w_clear = 1'b0;
        unique case (r_state)
            IDLE: begin
                s_ready = rst;
            end
            SHIFT: begin
                s_ready = rst && w_adv && (r_idx == 3'd0) && !r_last;
                w_step  = w_adv;
                w_bit   = r_byte[r_idx];
            end
            TAIL: begin
                w_step  = w_adv;
                w_clear = w_adv && (r_tail_cnt == 2'd0);
            end
            default: ;
        endcase
    end

    // Byte, bit index and tail counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte     <= '0;
            r_last     <= 1'b0;
            r_idx      <= '0;
            r_tail_cnt <= '0;
        end else if (w_accept) begin
            r_byte <= s_data;
            r_last <= s_last;
            r_idx  <= 3'd7;
        end else if ((r_state == SHIFT) && w_adv) begin
            r_idx <= r_idx - 3'd1;
            if (r_idx == 3'd0) r_tail_cnt <= TAIL_CNT_INIT;
        end else if ((r_state == TAIL) && w_adv) begin
            r_tail_cnt <= r_tail_cnt - 2'd1;
        end
    end

    // Output registers load only when the current symbol can be replaced
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_valid <= 1'b0;
            r_m_sym   <= '0;
            r_m_last  <= 1'b0;
        end else if (w_adv) begin
            unique case (r_state)
                SHIFT: begin
                    r_m_valid <= 1'b1;
                    r_m_sym   <= w_sym;
                    r_m_last  <= 1'b0;
                end
                TAIL: begin
                    r_m_valid <= 1'b1;
                    r_m_sym   <= w_sym;
                    r_m_last  <= (r_tail_cnt == 2'd0);
                end
                default: begin
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                end
            endcase
        end
    end

    assign m_valid = r_m_valid;
    assign m_sym   = r_m_sym;
    assign m_last  = r_m_last;

`ifdef CONV_ENC_PUNCTURE_EN
    // Symbol parity within the frame; restarts only at a new frame
    logic       r_punc_odd;
    logic [1:0] r_m_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_punc_odd <= 1'b0;
            r_m_mask   <= MASK_FULL;
        end else if (w_frame_start) begin
            r_punc_odd <= 1'b0;
        end else if (w_step) begin
            r_m_mask   <= r_punc_odd ? PUNC_MASK_ODD : PUNC_MASK_EVEN;
            r_punc_odd <= !r_punc_odd;
        end
    end

    assign m_mask = r_m_mask;
`else
    assign m_mask = MASK_FULL;
`endif

endmodule
